// File: rtl/mio_pkg.sv
// Shared definitions for the MIO UART transmitter: register map, FSM encodings
// and STATUS field layout.
package mio_pkg;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned DIV_W  = 16;

    localparam logic [3:0] ADDR_TXDATA = 4'h0;
    localparam logic [3:0] ADDR_STATUS = 4'h4;
    localparam logic [3:0] ADDR_BAUD   = 4'h8;

    localparam logic [DIV_W-1:0] DIV_MIN = 16'd2;

    localparam int unsigned ST_COUNT_W   = 6;
    localparam int unsigned ST_EMPTY_BIT = 6;
    localparam int unsigned ST_FULL_BIT  = 7;
    localparam int unsigned ST_BUSY_BIT  = 8;

    typedef enum logic {
        BUS_IDLE = 1'b0,
        BUS_ACK  = 1'b1
    } bus_state_e;

    typedef enum logic [1:0] {
        TX_IDLE  = 2'd0,
        TX_START = 2'd1,
        TX_DATA  = 2'd2,
        TX_STOP  = 2'd3
    } tx_state_e;

    function automatic logic [DATA_W-1:0] status_word(input logic busy, input logic full,
                                                      input logic empty,
                                                      input logic [ST_COUNT_W-1:0] cnt);
        logic [DATA_W-1:0] w;
        w = '0;
        w[ST_COUNT_W-1:0] = cnt;
        w[ST_EMPTY_BIT]   = empty;
        w[ST_FULL_BIT]    = full;
        w[ST_BUSY_BIT]    = busy;
        return w;
    endfunction

endpackage

// File: rtl/mio_uart_tx_fifo.sv
// Circular-buffer byte FIFO with occupancy count; push/pop are ignored when full/empty.
module mio_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]    count_q, count_d;
    logic             push_ok, pop_ok;

    assign full    = (count_q == CW'(DEPTH));
    assign empty   = (count_q == '0);
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign rdata   = mem_q[rd_ptr_q];
    assign count   = count_q;

    always_comb begin
        count_d = count_q;
        if (push_ok && !pop_ok) begin
            count_d = count_q + CW'(1);
        end else if (pop_ok && !push_ok) begin
            count_d = count_q - CW'(1);
        end
    end

    // Power-of-two depth lets the pointers wrap naturally.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            count_q <= count_d;
            if (push_ok) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop_ok)  rd_ptr_q <= rd_ptr_q + AW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q] <= wdata;
    end

endmodule

// File: rtl/mio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter: bus handshake FSM, TX byte FIFO and bit shifter.
module mio_uart_tx
    import mio_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH  = 8,
    parameter int unsigned DEFAULT_DIV = 868
) (
    input  logic        clk,
    input  logic        RSTN,
    input  logic        cs,
    input  logic        mem_w,
    input  logic [3:0]  addr_bus,
    input  logic [31:0] Cpu_data2bus,
    output logic [31:0] Cpu_data4bus,
    output logic        mio_ready,
    output logic        txd,
    output logic        irq_empty
);

    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;

    bus_state_e          bus_state_q;
    tx_state_e           tx_state_q;
    logic [DIV_W-1:0]    div_q, div_lat_q, baud_cnt_q, baud_wr;
    logic [DATA_W-1:0]   rdata_q, load_data;
    logic                ready_q, txd_q, irq_q;
    logic [2:0]          bit_q;
    logic [7:0]          shift_q, fifo_rdata;
    logic [CNT_W-1:0]    fifo_count;
    logic                fifo_full, fifo_empty;
    logic                accept, push, pop, bit_end, tx_idle_next, irq_d;

    assign accept       = (bus_state_q == BUS_IDLE) && cs &&
                          !(mem_w && (addr_bus == ADDR_TXDATA) && fifo_full);
    assign push         = accept && mem_w && (addr_bus == ADDR_TXDATA);
    assign bit_end      = (baud_cnt_q == div_lat_q - DIV_W'(1));
    assign tx_idle_next = (tx_state_q == TX_IDLE) || ((tx_state_q == TX_STOP) && bit_end);
    assign pop          = !fifo_empty && tx_idle_next;
    assign irq_d        = fifo_empty && !push && tx_idle_next;
    assign baud_wr      = (Cpu_data2bus[DIV_W-1:0] < DIV_MIN) ? DIV_MIN : Cpu_data2bus[DIV_W-1:0];

    always_comb begin
        load_data = '0;
        if (!mem_w) begin
            case (addr_bus)
                ADDR_STATUS: load_data = status_word(tx_state_q != TX_IDLE, fifo_full, fifo_empty,
                                                     ST_COUNT_W'(fifo_count));
                ADDR_BAUD:   load_data = {16'b0, div_q};
                default:     load_data = '0;
            endcase
        end
    end

    mio_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (RSTN),
        .push  (push),
        .pop   (pop),
        .wdata (Cpu_data2bus[7:0]),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    // Bus handshake: one ACK cycle per accepted access, load data presented only then.
    always_ff @(posedge clk) begin
        if (!RSTN) begin
            bus_state_q <= BUS_IDLE;
            ready_q     <= 1'b0;
            rdata_q     <= '0;
            div_q       <= DIV_W'(DEFAULT_DIV);
        end else begin
            ready_q <= 1'b0;
            rdata_q <= '0;
            case (bus_state_q)
                BUS_IDLE: begin
                    if (accept) begin
                        bus_state_q <= BUS_ACK;
                        ready_q     <= 1'b1;
                        rdata_q     <= load_data;
                        if (mem_w && (addr_bus == ADDR_BAUD)) div_q <= baud_wr;
                    end
                end
                BUS_ACK: bus_state_q <= BUS_IDLE;
            endcase
        end
    end

    // Frame shifter; txd is registered from the current state, so the line trails the FSM by one cycle.
    always_ff @(posedge clk) begin
        if (!RSTN) begin
            tx_state_q <= TX_IDLE;
            baud_cnt_q <= '0;
            bit_q      <= '0;
            shift_q    <= '0;
            div_lat_q  <= DIV_W'(DEFAULT_DIV);
            txd_q      <= 1'b1;
            irq_q      <= 1'b1;
        end else begin
            irq_q      <= irq_d;
            txd_q      <= (tx_state_q == TX_START) ? 1'b0 :
                          (tx_state_q == TX_DATA)  ? shift_q[0] : 1'b1;
            baud_cnt_q <= bit_end ? '0 : baud_cnt_q + DIV_W'(1);
            case (tx_state_q)
                TX_IDLE: begin
                    baud_cnt_q <= '0;
                    if (pop) begin
                        tx_state_q <= TX_START;
                        shift_q    <= fifo_rdata;
                        div_lat_q  <= div_q;
                    end
                end
                TX_START: begin
                    if (bit_end) begin
                        tx_state_q <= TX_DATA;
                        bit_q      <= '0;
                    end
                end
                TX_DATA: begin
                    if (bit_end) begin
                        shift_q <= {1'b0, shift_q[7:1]};
                        bit_q   <= bit_q + 3'd1;
                        if (bit_q == 3'd7) tx_state_q <= TX_STOP;
                    end
                end
                TX_STOP: begin
                    if (bit_end) begin
                        if (pop) begin
                            tx_state_q <= TX_START;
                            shift_q    <= fifo_rdata;
                            div_lat_q  <= div_q;
                        end else begin
                            tx_state_q <= TX_IDLE;
                        end
                    end
                end
            endcase
        end
    end

    assign mio_ready    = ready_q;
    assign Cpu_data4bus = rdata_q;
    assign txd          = txd_q;
    assign irq_empty    = irq_q;

endmodule

// File: tb/tb_mio_uart_tx.sv
// Directed and randomized bench for mio_uart_tx with a serial-line frame checker.
module tb_mio_uart_tx;

    logic        clk = 1'b0;
    logic        RSTN = 1'b0;
    logic        cs = 1'b0;
    logic        mem_w = 1'b0;
    logic [3:0]  addr_bus = 4'h0;
    logic [31:0] Cpu_data2bus = 32'h0;
    logic [31:0] Cpu_data4bus;
    logic        mio_ready, txd, irq_empty;

    mio_uart_tx #(.FIFO_DEPTH(8), .DEFAULT_DIV(868)) dut (
        .clk          (clk),
        .RSTN         (RSTN),
        .cs           (cs),
        .mem_w        (mem_w),
        .addr_bus     (addr_bus),
        .Cpu_data2bus (Cpu_data2bus),
        .Cpu_data4bus (Cpu_data4bus),
        .mio_ready    (mio_ready),
        .txd          (txd),
        .irq_empty    (irq_empty)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  data;
        int unsigned div;
    } frame_t;

    frame_t      exp_q[$];
    int unsigned n_checks = 0;
    int unsigned n_pass = 0;
    int unsigned cyc = 0;
    int unsigned div_m = 868;
    int unsigned rx_frames = 0;
    int unsigned last_end_cyc = 0;
    int          last_gap = -1;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    endtask

    function automatic logic [31:0] exp_status(input int unsigned busy, input int unsigned count,
                                               input int unsigned depth);
        int unsigned v;
        v = count % 64;
        if (count == 0)     v += 64;
        if (count == depth) v += 128;
        if (busy != 0)      v += 256;
        return 32'(v);
    endfunction

    // Expected serial line: start 0, data LSB first, stop 1, each bit held for the frame's divisor.
    initial begin : line_monitor
        frame_t      f;
        logic [9:0]  bits;
        logic        ok;
        logic        aborted;
        forever begin
            @(negedge clk);
            if (RSTN !== 1'b1 || txd !== 1'b0) continue;
            if (exp_q.size() == 0) begin
                check("unexpected_frame_txd", 32'(txd), 32'd1);
                continue;
            end
            f        = exp_q.pop_front();
            last_gap = int'(cyc) - int'(last_end_cyc) - 1;
            bits     = {1'b1, f.data, 1'b0};
            aborted  = 1'b0;
            for (int b = 0; b < 10 && !aborted; b++) begin
                ok = 1'b1;
                for (int unsigned i = 0; i < f.div; i++) begin
                    if (b != 0 || i != 0) @(negedge clk);
                    if (RSTN !== 1'b1) begin
                        aborted = 1'b1;
                        break;
                    end
                    if (txd !== bits[b]) ok = 1'b0;
                end
                if (!aborted) check($sformatf("frame%0d_byte%02h_bit%0d", rx_frames, f.data, b),
                                    32'(ok), 32'd1);
            end
            if (!aborted) begin
                rx_frames++;
                last_end_cyc = cyc;
            end
        end
    end

    task automatic bus(input logic we, input logic [3:0] a, input logic [31:0] wd,
                       output logic [31:0] rd, output int unsigned waited);
        logic quiet;
        quiet  = 1'b1;
        waited = 0;
        rd     = '0;
        @(posedge clk); #1;
        cs = 1'b1; mem_w = we; addr_bus = a; Cpu_data2bus = wd;
        forever begin
            @(posedge clk); #1;
            waited++;
            if (mio_ready === 1'b1) begin
                rd = Cpu_data4bus;
                break;
            end
            if (Cpu_data4bus !== 32'h0) quiet = 1'b0;
            if (waited > 20000) break;
        end
        cs = 1'b0; mem_w = 1'b0;
        check("access_completed", 32'(mio_ready), 32'd1);
        check("rdata_zero_while_not_ready", 32'(quiet), 32'd1);
    endtask

    task automatic store_tx(input logic [7:0] b, output int unsigned waited);
        logic [31:0] rd;
        bus(1'b1, 4'h0, {24'hABCDEF, b}, rd, waited);
        exp_q.push_back('{data: b, div: div_m});
    endtask

    task automatic store_baud(input logic [31:0] v);
        logic [31:0] rd;
        int unsigned w;
        bus(1'b1, 4'h8, v, rd, w);
        div_m = (v[15:0] < 16'd2) ? 2 : int'(v[15:0]);
    endtask

    task automatic load(input logic [3:0] a, input logic [31:0] exp, input string tag);
        logic [31:0] rd;
        int unsigned w;
        bus(1'b0, a, 32'hDEADBEEF, rd, w);
        check(tag, rd, exp);
    endtask

    task automatic wait_rx(input int unsigned n, input int unsigned budget);
        int unsigned t = 0;
        while (rx_frames < n && t < budget) begin
            @(posedge clk); #1;
            t++;
        end
        check("rx_frame_count", 32'(rx_frames), 32'(n));
    endtask

    initial begin : stimulus
        int unsigned w;
        int unsigned base;
        logic [31:0] rd;
        logic        line_ok;
        int unsigned t;
        int unsigned nb;

        // Reset values
        repeat (3) @(posedge clk);
        #1;
        check("rst_txd", 32'(txd), 32'd1);
        check("rst_irq_empty", 32'(irq_empty), 32'd1);
        check("rst_mio_ready", 32'(mio_ready), 32'd0);
        check("rst_rdata", Cpu_data4bus, 32'd0);
        RSTN = 1'b1;
        load(4'h4, exp_status(0, 0, 8), "status_after_reset");
        load(4'h8, 32'd868, "baud_after_reset");
        load(4'h0, 32'd0, "txdata_reads_zero");
        bus(1'b1, 4'h4, 32'hFFFF_FFFF, rd, w);
        bus(1'b1, 4'hC, 32'h1234_5678, rd, w);
        load(4'hC, 32'd0, "unmapped_reads_zero");
        load(4'h8, 32'd868, "baud_unchanged_by_stray_writes");

        // Default-rate frame and push-to-line latency
        store_tx(8'h55, w);
        check("irq_low_in_ack", 32'(irq_empty), 32'd0);
        @(posedge clk); #1;
        check("ready_single_pulse", 32'(mio_ready), 32'd0);
        check("txd_high_ack_plus1", 32'(txd), 32'd1);
        @(posedge clk); #1;
        check("txd_low_ack_plus2", 32'(txd), 32'd0);
        wait_rx(1, 12000);
        @(posedge clk); #1;
        check("irq_after_frame", 32'(irq_empty), 32'd1);

        // Divisor programming and clamp
        store_baud(32'd2);
        load(4'h8, 32'd2, "baud_rd_2");
        store_baud(32'd1);
        load(4'h8, 32'd2, "baud_clamp_1");
        store_baud(32'd0);
        load(4'h8, 32'd2, "baud_clamp_0");
        store_baud(32'hABCD_0007);
        load(4'h8, 32'h0000_0007, "baud_upper_ignored");
        store_baud(32'd2);
        store_tx(8'hA5, w);
        wait_rx(2, 200);

        // Randomized bytes at random divisors
        for (int r = 0; r < 3; r++) begin
            store_baud(32'($urandom_range(6, 2)));
            load(4'h8, 32'(div_m), "baud_rand_rd");
            nb   = $urandom_range(5, 2);
            base = rx_frames;
            for (int k = 0; k < int'(nb); k++) store_tx(8'($urandom), w);
            wait_rx(base + nb, 2000);
        end

        // Back-to-back frames with no idle gap
        store_baud(32'd2);
        base = rx_frames;
        store_tx(8'h00, w);
        store_tx(8'hFF, w);
        wait_rx(base + 2, 200);
        check("contiguous_gap", 32'(last_gap), 32'd0);

        // Divisor change mid-frame applies to the next frame only
        base = rx_frames;
        store_tx(8'h3C, w);
        repeat (4) @(posedge clk);
        store_baud(32'd4);
        store_tx(8'hC3, w);
        wait_rx(base + 2, 300);

        // FIFO full stall: first byte goes straight to the shifter, eight more fill the FIFO
        store_baud(32'd20);
        base = rx_frames;
        for (int k = 0; k < 9; k++) begin
            store_tx(8'($urandom), w);
            check($sformatf("fill_store%0d_wait", k), 32'(w), 32'd1);
        end
        load(4'h4, exp_status(1, 8, 8), "status_full");
        store_tx(8'h81, w);
        check("stall_held_off", 32'(w > 100), 32'd1);
        check("stall_released_by_pop", 32'(rx_frames), 32'(base + 1));
        wait_rx(base + 10, 4000);

        // Reset in the middle of DATA with bytes queued
        store_baud(32'd8);
        for (int k = 0; k < 4; k++) store_tx(8'($urandom | 32'h1), w);
        t = 0;
        while (txd !== 1'b0 && t < 100) begin
            @(posedge clk); #1;
            t++;
        end
        check("frame_started_before_reset", 32'(txd), 32'd0);
        repeat (20) @(posedge clk);
        #1;
        RSTN = 1'b0;
        exp_q.delete();
        @(posedge clk); #1;
        check("reset_txd_high", 32'(txd), 32'd1);
        check("reset_irq_empty", 32'(irq_empty), 32'd1);
        check("reset_ready_low", 32'(mio_ready), 32'd0);
        RSTN  = 1'b1;
        div_m = 868;
        load(4'h4, exp_status(0, 0, 8), "status_after_mid_reset");
        load(4'h8, 32'd868, "baud_after_mid_reset");
        line_ok = 1'b1;
        repeat (300) begin
            @(posedge clk); #1;
            if (txd !== 1'b1 || irq_empty !== 1'b1) line_ok = 1'b0;
        end
        check("no_frames_after_reset", 32'(line_ok), 32'd1);

        check("expected_frames_drained", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
